reaction_lcd_writer: RTL and testbench
======================================

// Module: reaction_lcd_writer
// PURPOSE
// - Downstream display stage for the reaction timer. Takes a 16-bit reaction time in ms plus a strobe.
// - Runs the HD44780 8-bit power-up sequence, converts the value to decimal and writes it to line 1.
// - Uses a timed byte-write engine: setup, enable pulse, hold.
// - Replaces the timer's free-running lcd_data/lcd_en drive with protocol-correct timing.
// PARAMETERS
// - CLOCK_FREQ      50000000  system clock in Hz (documentation only; the cycle counts below are authoritative)
// - POWERUP_CYCLES  750000    idle wait after reset before the first command (15 ms)
// - EN_CYCLES       25        lcd_en high width in clocks (500 ns)
// - CMD_WAIT        2500      post-pulse wait for normal command or data bytes (50 us)
// - CLR_WAIT        82000     post-pulse wait after the clear command 0x01 (1.64 ms)
// PORTS
// - clk         in   1   system clock, rising edge
// - reset       in   1   asynchronous, active-high reset
// - time_in     in   16  reaction time in ms, unsigned
// - time_valid  in   1   single-cycle strobe; time_in is sampled on this cycle
// - busy        out  1   high while powering up, initialising, converting or writing
// - init_done   out  1   goes high once the init sequence completes; stays high until reset
// - lcd_data    out  8   LCD DB7..DB0
// - lcd_rs      out  1   0 = command byte, 1 = character byte
// - lcd_en      out  1   LCD enable strobe
// BEHAVIOUR
// - Reset (async, active-high) forces all outputs to 0 except busy = 1. All counters and pending flags clear.
// - Reset asserted mid-write drops lcd_en at once and restarts from POWER_UP.
// - States: POWER_UP -> INIT (4 bytes) -> IDLE -> CONVERT -> WRITE (6 or 9 bytes) -> IDLE.
// - POWER_UP: count POWERUP_CYCLES with lcd_en = 0.
// - INIT: send 0x38, 0x0C, 0x01, 0x06 with rs = 0.
//   - The wait after 0x01 is CLR_WAIT; every other byte waits CMD_WAIT.
//   - init_done rises on the cycle that INIT ends.
// - Byte write engine (identical for every byte):
//   - Cycle 0: drive lcd_data and lcd_rs.
//   - Cycles 1..EN_CYCLES: lcd_en = 1.
//   - Then lcd_en = 0 and the wait starts.
//   - lcd_data and lcd_rs hold their value until the next byte is driven.
// - IDLE: busy = 0. A time_valid in this state latches time_in and enters CONVERT.
// - CONVERT: sequential double-dabble, 1 bit per clock, exactly 16 clocks.
//   - Produces 5 BCD digits (max 65535).
//   - Before each shift, add 3 to any nibble >= 5.
// - WRITE sends, in order:
//   - Command 0x80 (DDRAM address 0), rs = 0.
//   - 5 characters, rs = 1, ten-thousands digit first.
//   - Each digit is 0x30 + d. Leading zeros become 0x20 (space); the units digit is always a numeral.
// - time_valid outside IDLE (while busy) stores time_in in a 1-deep pending register.
//   - A later strobe overwrites it; the last value wins.
//   - On returning to IDLE with pending set: clear pending, load the value and enter CONVERT on the next clock.
//   - busy stays high through that transition.
// - time_valid in the same cycle that WRITE finishes counts as pending, not dropped.
// - time_valid during POWER_UP or INIT is held as pending and drawn once init_done rises.
// - No wrap-around is possible; all 16-bit inputs are displayable.
// CONFIGURATION
// - LCD_UNITS_EN defined: WRITE appends 3 characters, 0x20 0x6D 0x73 (" ms"), after the units digit, for 9 bytes total.
// - LCD_UNITS_EN undefined: 6 bytes total, digits only, no suffix logic.
// TESTING (POWERUP_CYCLES=100, EN_CYCLES=2, CMD_WAIT=10, CLR_WAIT=40)
// - Release reset -> lcd_en stays 0 for 100 clocks.
//   - Then bytes 0x38, 0x0C, 0x01, 0x06 with rs = 0, each with a 2-clock en pulse.
//   - Gap after 0x01 is 40 clocks; init_done rises after the final 10-clock wait.
// - Strobe 1234 in IDLE -> 16 clocks of CONVERT, then 0x80 (rs 0), then 0x20 0x31 0x32 0x33 0x34 (rs 1); busy falls afterwards.
// - Strobe 0 -> 0x20 0x20 0x20 0x20 0x30. Strobe 65535 -> 0x36 0x35 0x35 0x33 0x35.
// - Strobe 7, then 9 and 42 while busy -> "    7" is drawn, then exactly one redraw "   42"; 9 is never drawn.
// - Assert reset during the en-high phase of a character byte -> lcd_en = 0 that cycle.
//   - After release, a full POWER_UP and INIT sequence repeats; pending is cleared.
// - With LCD_UNITS_EN, strobe 250 -> 0x80, then 0x20 0x20 0x32 0x35 0x30 0x20 0x6D 0x73.

Source files
------------

// File: rtl/reaction_lcd_writer_if.sv
// Strobe/status and LCD pin bundle between the reaction timer and its display writer.
// master: the side supplying time_in/time_valid; slave: the writer driving the LCD pins.
interface reaction_lcd_writer_if;
    logic [15:0] time_in;
    logic        time_valid;
    logic        busy;
    logic        init_done;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_en;

    modport master (
        output time_in, time_valid,
        input  busy, init_done, lcd_data, lcd_rs, lcd_en
    );

    modport slave (
        input  time_in, time_valid,
        output busy, init_done, lcd_data, lcd_rs, lcd_en
    );
endinterface

// File: rtl/reaction_lcd_writer.sv
// HD44780 8-bit init, 16-bit binary-to-BCD conversion and line-1 writer for the reaction timer.
// Optional build macro LCD_UNITS_EN appends " ms" after the units digit.
module reaction_lcd_writer #(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned EN_CYCLES      = 25,
    parameter int unsigned CMD_WAIT       = 2500,
    parameter int unsigned CLR_WAIT       = 82000
) (
    input  logic                 clk,
    input  logic                 reset,
    reaction_lcd_writer_if.slave bus
);
    localparam int unsigned MAX_A = (POWERUP_CYCLES > CLR_WAIT) ? POWERUP_CYCLES : CLR_WAIT;
    localparam int unsigned MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = (MAX_C > 16) ? $clog2(MAX_C) : 4;

    localparam logic [CW-1:0] PU_LAST   = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(15);

`ifdef LCD_UNITS_EN
    localparam logic [3:0] WR_LAST = 4'd8;
`else
    localparam logic [3:0] WR_LAST = 4'd5;
`endif

    if (CLOCK_FREQ == 0 || POWERUP_CYCLES == 0 || EN_CYCLES == 0 ||
        CMD_WAIT == 0 || CLR_WAIT == 0) begin : g_bad_cfg
        $error("reaction_lcd_writer: timing parameters must be non-zero");
    end

    typedef enum logic [2:0] {ST_POWER_UP, ST_INIT, ST_IDLE, ST_CONVERT, ST_WRITE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          init_done_q, init_done_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [15:0]   bin_q, bin_d;
    logic [19:0]   bcd_q, bcd_d;

    logic [7:0]    chars [0:4];
    logic [3:0]    digit;
    logic          lead;
    logic [3:0]    nxt_idx;
    logic [7:0]    nxt_byte;
    logic [CW-1:0] wait_last;
    logic [19:0]   bcd_adj;

    // Leading-zero blanking: a digit is a space while every digit above it is zero.
    always_comb begin
        lead  = 1'b1;
        digit = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            digit = bcd_q[19 - 4*i -: 4];
            if (digit != 4'd0 || i == 4) lead = 1'b0;
            chars[i] = lead ? 8'h20 : {4'h3, digit};
        end
    end

    always_comb begin
        nxt_idx  = idx_q + 4'd1;
        nxt_byte = 8'h20;
        if (state_q == ST_INIT) begin
            case (nxt_idx)
                4'd1:    nxt_byte = 8'h0C;
                4'd2:    nxt_byte = 8'h01;
                4'd3:    nxt_byte = 8'h06;
                default: nxt_byte = 8'h38;
            endcase
        end else begin
            case (nxt_idx)
                4'd1:    nxt_byte = chars[0];
                4'd2:    nxt_byte = chars[1];
                4'd3:    nxt_byte = chars[2];
                4'd4:    nxt_byte = chars[3];
                4'd5:    nxt_byte = chars[4];
`ifdef LCD_UNITS_EN
                4'd6:    nxt_byte = 8'h20;
                4'd7:    nxt_byte = 8'h6D;
                4'd8:    nxt_byte = 8'h73;
`endif
                default: nxt_byte = 8'h20;
            endcase
        end
        wait_last = (state_q == ST_INIT && idx_q == 4'd2) ? CLR_LAST : CMD_LAST;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        init_done_d = init_done_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;

        if (bus.time_valid && state_q != ST_IDLE) begin
            pend_d     = 1'b1;
            pend_val_d = bus.time_in;
        end

        case (state_q)
            ST_POWER_UP: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    data_d  = 8'h38;
                    rs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT, ST_WRITE: begin
                case (phase_q)
                    PH_SETUP: begin
                        en_d    = 1'b1;
                        phase_d = PH_EN;
                        cnt_d   = '0;
                    end
                    PH_EN: begin
                        if (cnt_q == EN_LAST) begin
                            en_d    = 1'b0;
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q != wait_last) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (idx_q != ((state_q == ST_INIT) ? 4'd3 : WR_LAST)) begin
                            cnt_d   = '0;
                            idx_d   = nxt_idx;
                            data_d  = nxt_byte;
                            rs_d    = (state_q == ST_WRITE);
                            phase_d = PH_SETUP;
                        end else begin
                            // Sequence finished: a strobe this cycle or a held one goes
                            // straight to CONVERT so busy never dips low in between.
                            cnt_d = '0;
                            bcd_d = '0;
                            if (state_q == ST_INIT) init_done_d = 1'b1;
                            if (bus.time_valid) begin
                                bin_d   = bus.time_in;
                                pend_d  = 1'b0;
                                state_d = ST_CONVERT;
                            end else if (pend_q) begin
                                bin_d   = pend_val_q;
                                pend_d  = 1'b0;
                                state_d = ST_CONVERT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                endcase
            end
            ST_IDLE: begin
                if (bus.time_valid) begin
                    bin_d   = bus.time_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                if (cnt_q == CONV_LAST) begin
                    state_d = ST_WRITE;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    data_d  = 8'h80;
                    rs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_POWER_UP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_POWER_UP;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.init_done = init_done_q;
    assign bus.lcd_data  = data_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_en    = en_q;
endmodule

// File: tb/tb_reaction_lcd_writer.sv
// Bench for reaction_lcd_writer: LCD byte monitor plus a decimal-formatting reference model.
// Honours LCD_UNITS_EN the same way as the design.
module tb_reaction_lcd_writer;
    localparam int PU  = 100;
    localparam int EN  = 2;
    localparam int CMD = 10;
    localparam int CLR = 40;
`ifdef LCD_UNITS_EN
    localparam int NB = 9;
`else
    localparam int NB = 6;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    reaction_lcd_writer_if bus ();

    reaction_lcd_writer #(
        .POWERUP_CYCLES(PU),
        .EN_CYCLES     (EN),
        .CMD_WAIT      (CMD),
        .CLR_WAIT      (CLR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Byte monitor: every rising lcd_en records {rs,data}, its cycle, and later its width.
    int         cyc     = 0;
    logic       prev_en = 1'b0;
    int         hi      = 0;
    logic [8:0] mon_byte [$];
    int         mon_rise [$];
    int         mon_width[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.lcd_en && !prev_en) begin
            mon_byte.push_back({bus.lcd_rs, bus.lcd_data});
            mon_rise.push_back(cyc);
        end
        if (bus.lcd_en) hi++;
        else if (prev_en) begin
            mon_width.push_back(hi);
            hi = 0;
        end
        prev_en = bus.lcd_en;
    end

    logic [8:0] exp_b [0:8];
    int         exp_n;

    task automatic build_exp(input int unsigned v);
        int unsigned d [5];
        bit lead;
        d[0] = (v / 10000) % 10;
        d[1] = (v / 1000) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 10) % 10;
        d[4] = v % 10;
        exp_b[0] = 9'h080;
        lead = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (d[i] != 0 || i == 4) lead = 1'b0;
            exp_b[i+1] = lead ? 9'h120 : (9'h130 + 9'(d[i]));
        end
        for (int i = 6; i < 9; i++) exp_b[i] = '0;
`ifdef LCD_UNITS_EN
        exp_b[6] = 9'h120;
        exp_b[7] = 9'h16D;
        exp_b[8] = 9'h173;
        exp_n = 9;
`else
        exp_n = 6;
`endif
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input int unsigned v);
        bus.time_in    = 16'(v);
        bus.time_valid = 1'b1;
        step();
        bus.time_valid = 1'b0;
    endtask

    task automatic clear_mon();
        mon_byte.delete();
        mon_rise.delete();
        mon_width.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (!bus.busy) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
        total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done); end
        total++; if (bus.lcd_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", bus.lcd_en); end
        total++; if (bus.lcd_rs !== 1'b0) begin bad++; $display("FAIL rst_rs got=%b exp=0", bus.lcd_rs); end
        total++; if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.lcd_data); end
    endtask

    task automatic test_init();
        int c0, en_hits, done_at, r0, r1, r2, r3, n, busy_at_done;
        logic [8:0] iexp [0:3];
        iexp = '{9'h038, 9'h00C, 9'h001, 9'h006};
        clear_mon();
        c0 = cyc;
        reset = 1'b0;
        en_hits = 0;
        for (int i = 0; i < PU; i++) begin
            step();
            if (bus.lcd_en) en_hits++;
        end
        total++; if (en_hits !== 0) begin bad++; $display("FAIL pu_en_quiet got=%0d exp=0", en_hits); end
        done_at = -1;
        busy_at_done = -1;
        for (int i = 0; i < 400 && done_at < 0; i++) begin
            step();
            if (bus.init_done) begin
                done_at = cyc;
                busy_at_done = int'(bus.busy);
            end
        end
        total++; if (done_at < 0) begin bad++; $display("FAIL init_timeout got=none exp=init_done"); end
        n = mon_byte.size();
        total++; if (n !== 4) begin bad++; $display("FAIL init_count got=%0d exp=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++;
            if (mon_byte[i] !== iexp[i]) begin bad++; $display("FAIL init_byte%0d got=%h exp=%h", i, mon_byte[i], iexp[i]); end
        end
        for (int i = 0; i < mon_width.size(); i++) begin
            total++;
            if (mon_width[i] !== EN) begin bad++; $display("FAIL init_width%0d got=%0d exp=%0d", i, mon_width[i], EN); end
        end
        if (n >= 4) begin
            r0 = c0 + PU + 1;
            r1 = r0 + EN + CMD + 1;
            r2 = r1 + EN + CMD + 1;
            r3 = r2 + EN + CLR + 1;
            total++; if (mon_rise[0] !== r0) begin bad++; $display("FAIL init_rise0 got=%0d exp=%0d", mon_rise[0], r0); end
            total++; if (mon_rise[1] !== r1) begin bad++; $display("FAIL init_rise1 got=%0d exp=%0d", mon_rise[1], r1); end
            total++; if (mon_rise[2] !== r2) begin bad++; $display("FAIL init_rise2 got=%0d exp=%0d", mon_rise[2], r2); end
            total++; if (mon_rise[3] !== r3) begin bad++; $display("FAIL init_rise3_clr got=%0d exp=%0d", mon_rise[3], r3); end
            total++; if (done_at !== r3 + EN + CMD) begin bad++; $display("FAIL init_done_time got=%0d exp=%0d", done_at, r3 + EN + CMD); end
        end
        total++; if (busy_at_done !== 0) begin bad++; $display("FAIL init_busy got=%0d exp=0", busy_at_done); end
    endtask

    task automatic test_display(input int unsigned v);
        int s, at, n, first, last;
        bit ok;
        build_exp(v);
        clear_mon();
        s = cyc;
        strobe(v);
        wait_idle(400, ok, at);
        total++; if (!ok) begin bad++; $display("FAIL disp_timeout v=%0d got=busy exp=idle", v); end
        n = mon_byte.size();
        total++; if (n !== exp_n) begin bad++; $display("FAIL disp_count v=%0d got=%0d exp=%0d", v, n, exp_n); end
        for (int i = 0; i < exp_n && i < n; i++) begin
            total++;
            if (mon_byte[i] !== exp_b[i]) begin bad++; $display("FAIL disp_byte%0d v=%0d got=%h exp=%h", i, v, mon_byte[i], exp_b[i]); end
        end
        first = (n > 0) ? mon_rise[0] : -1;
        total++; if (first !== s + 18) begin bad++; $display("FAIL disp_latency v=%0d got=%0d exp=%0d", v, first, s + 18); end
        for (int i = 1; i < n; i++) begin
            total++;
            if (mon_rise[i] - mon_rise[i-1] !== EN + CMD + 1) begin
                bad++; $display("FAIL disp_gap%0d v=%0d got=%0d exp=%0d", i, v, mon_rise[i] - mon_rise[i-1], EN + CMD + 1);
            end
        end
        for (int i = 0; i < mon_width.size(); i++) begin
            total++;
            if (mon_width[i] !== EN) begin bad++; $display("FAIL disp_width%0d v=%0d got=%0d exp=%0d", i, v, mon_width[i], EN); end
        end
        last = (n > 0) ? mon_rise[n-1] : -1;
        total++; if (at !== last + EN + CMD) begin bad++; $display("FAIL disp_idle_time v=%0d got=%0d exp=%0d", v, at, last + EN + CMD); end
        repeat (3) step();
    endtask

    task automatic test_values();
        int unsigned fixed [5] = '{1234, 0, 65535, 10, 100};
        foreach (fixed[i]) test_display(fixed[i]);
        for (int i = 0; i < 5; i++) test_display($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) test_display($urandom_range(0, 999));
    endtask

    task automatic test_back_to_back();
        logic [8:0] e7 [0:8];
        int at, n;
        bit ok;
        build_exp(7);
        e7 = exp_b;
        build_exp(42);
        clear_mon();
        strobe(7);
        repeat (5) step();
        strobe(9);
        for (int i = 0; i < 300 && mon_byte.size() < 2; i++) step();
        strobe(42);
        wait_idle(600, ok, at);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=busy exp=idle"); end
        n = mon_byte.size();
        total++; if (n !== 2 * NB) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", n, 2 * NB); end
        for (int i = 0; i < NB && i < n; i++) begin
            total++;
            if (mon_byte[i] !== e7[i]) begin bad++; $display("FAIL b2b_first%0d got=%h exp=%h", i, mon_byte[i], e7[i]); end
        end
        for (int i = 0; i < NB && i + NB < n; i++) begin
            total++;
            if (mon_byte[i+NB] !== exp_b[i]) begin bad++; $display("FAIL b2b_redraw%0d got=%h exp=%h", i, mon_byte[i+NB], exp_b[i]); end
        end
        repeat (60) step();
        n = mon_byte.size();
        total++; if (n !== 2 * NB) begin bad++; $display("FAIL b2b_no_third got=%0d exp=%0d", n, 2 * NB); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", bus.busy); end
    endtask

    task automatic test_valid_at_finish();
        logic [8:0] e1 [0:8];
        int unsigned v1, v2;
        int at, n, r;
        bit ok;
        v1 = $urandom_range(0, 65535);
        v2 = $urandom_range(0, 65535);
        build_exp(v1);
        e1 = exp_b;
        build_exp(v2);
        clear_mon();
        strobe(v1);
        for (int i = 0; i < 300 && mon_byte.size() < NB; i++) step();
        r = (mon_rise.size() >= NB) ? mon_rise[NB-1] : cyc;
        for (int i = 0; i < 100 && cyc < r + EN + CMD - 1; i++) step();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fin_busy_before got=%b exp=1", bus.busy); end
        strobe(v2);
        wait_idle(600, ok, at);
        total++; if (!ok) begin bad++; $display("FAIL fin_timeout got=busy exp=idle"); end
        n = mon_byte.size();
        total++; if (n !== 2 * NB) begin bad++; $display("FAIL fin_count got=%0d exp=%0d", n, 2 * NB); end
        for (int i = 0; i < NB && i < n; i++) begin
            total++;
            if (mon_byte[i] !== e1[i]) begin bad++; $display("FAIL fin_first%0d got=%h exp=%h", i, mon_byte[i], e1[i]); end
        end
        for (int i = 0; i < NB && i + NB < n; i++) begin
            total++;
            if (mon_byte[i+NB] !== exp_b[i]) begin bad++; $display("FAIL fin_redraw%0d got=%h exp=%h", i, mon_byte[i+NB], exp_b[i]); end
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int n, done;
        clear_mon();
        strobe($urandom_range(1, 65535));
        repeat (3) step();
        strobe($urandom_range(1, 65535));
        for (int i = 0; i < 300 && mon_byte.size() < 2; i++) step();
        total++; if (bus.lcd_en !== 1'b1 || bus.lcd_rs !== 1'b1) begin
            bad++; $display("FAIL mid_char_en got=en%b/rs%b exp=en1/rs1", bus.lcd_en, bus.lcd_rs);
        end
        reset = 1'b1;
        #1;
        total++; if (bus.lcd_en !== 1'b0) begin bad++; $display("FAIL mid_en_drop got=%b exp=0", bus.lcd_en); end
        total++; if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", bus.lcd_data); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        step();
        reset = 1'b0;
        clear_mon();
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (bus.init_done) done = 1;
        end
        total++; if (done !== 1) begin bad++; $display("FAIL mid_reinit got=%0d exp=1", done); end
        repeat (100) step();
        n = mon_byte.size();
        total++; if (n !== 4) begin bad++; $display("FAIL mid_pending_cleared got=%0d exp=4", n); end
        total++; if (n > 0 && mon_byte[0] !== 9'h038) begin bad++; $display("FAIL mid_first_cmd got=%h exp=038", mon_byte[0]); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_pending_init();
        int unsigned v;
        int at, n;
        bit ok;
        v = $urandom_range(0, 65535);
        build_exp(v);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_mon();
        repeat (10) step();
        strobe(v);
        wait_idle(800, ok, at);
        total++; if (!ok) begin bad++; $display("FAIL pinit_timeout got=busy exp=idle"); end
        n = mon_byte.size();
        total++; if (n !== 4 + NB) begin bad++; $display("FAIL pinit_count got=%0d exp=%0d", n, 4 + NB); end
        for (int i = 0; i < NB && i + 4 < n; i++) begin
            total++;
            if (mon_byte[i+4] !== exp_b[i]) begin bad++; $display("FAIL pinit_byte%0d got=%h exp=%h", i, mon_byte[i+4], exp_b[i]); end
        end
        total++; if (bus.init_done !== 1'b1) begin bad++; $display("FAIL pinit_done got=%b exp=1", bus.init_done); end
    endtask

    initial begin
        bus.time_in    = '0;
        bus.time_valid = 1'b0;
        test_reset();
        test_init();
        test_values();
        test_back_to_back();
        test_valid_at_finish();
        test_reset_mid();
        test_pending_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
